// File: rtl/lab5_debounce_pkg.sv
// lab5_debounce_pkg: FSM state encoding, default debounce length and clog2 helper for the debouncer
package lab5_debounce_pkg;
  typedef enum logic {ST_STABLE = 1'b0, ST_COUNTING = 1'b1} state_t;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/lab5_debounce_channel.sv
// lab5_debounce_channel: one button (clk, reset, in_raw -> db_out, press_pulse, release_pulse, busy): 2-flop sync, counter debounce, edge strobes
module lab5_debounce_channel
  import lab5_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W = 19
) (
  input  logic clk,
  input  logic reset,
  input  logic in_raw,
  output logic db_out,
  output logic press_pulse,
  output logic release_pulse,
  output logic busy
);
  logic s1, s2, db_n, press_n, release_n, diff, done, accept;
  logic [CNT_W-1:0] cnt, cnt_n;
  state_t state, state_n;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      db_out <= 1'b1;
      press_pulse <= 1'b0;
      release_pulse <= 1'b0;
      cnt <= '0;
      state <= ST_STABLE;
    end else begin
      s1 <= in_raw;
      s2 <= s1;
      db_out <= db_n;
      press_pulse <= press_n;
      release_pulse <= release_n;
      cnt <= cnt_n;
      state <= state_n;
    end
  end
  assign diff = s2 != db_out;
  assign done = cnt == CNT_W'(DEBOUNCE_CYCLES - 1);
  assign busy = state == ST_COUNTING;
  always_comb begin
    accept = busy && diff && done;
    state_n = diff && !accept ? ST_COUNTING : ST_STABLE;
    cnt_n = state_n == ST_COUNTING ? cnt + 1'b1 : '0;
    db_n = accept ? s2 : db_out;
    press_n = accept && !s2;
    release_n = accept && s2;
  end
endmodule

// File: rtl/lab5_button_debounce.sv
// lab5_button_debounce: WIDTH active-low buttons (in_raw) -> debounced db_out plus press/release strobes and busy per channel
module lab5_button_debounce
  import lab5_debounce_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W = 19
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_raw,
  output logic [WIDTH-1:0] db_out,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse,
  output logic [WIDTH-1:0] busy
);
  if (DEBOUNCE_CYCLES < 2 || CNT_W < clog2(DEBOUNCE_CYCLES)) begin : g_bad_params
    $error("lab5_button_debounce: DEBOUNCE_CYCLES must be >= 2 and fit in CNT_W bits");
  end
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    lab5_debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W(CNT_W)
    ) u_ch (
      .clk(clk),
      .reset(reset),
      .in_raw(in_raw[i]),
      .db_out(db_out[i]),
      .press_pulse(press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .busy(busy[i])
    );
  end
endmodule

// File: tb/tb_lab5_button_debounce.sv
// tb_lab5_button_debounce: directed stimulus with a run-length reference model checked every cycle
module tb_lab5_button_debounce;
  localparam int D = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] in_raw = 4'hF;
  logic [3:0] db_out, press_pulse, release_pulse, busy;
  int n_checks = 0;
  int n_fail = 0;

  lab5_button_debounce #(.WIDTH(4), .DEBOUNCE_CYCLES(D), .CNT_W(4)) dut (
    .clk(clk),
    .reset(reset),
    .in_raw(in_raw),
    .db_out(db_out),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the value each channel sees is in_raw delayed by two samples;
  // a level is accepted after D consecutive samples that disagree with the output.
  logic [3:0] d1_m = 4'hF, d2_m = 4'hF, db_m = 4'hF, pr_m = 4'h0, rl_m = 4'h0;
  int run_m [4] = '{0, 0, 0, 0};
  logic [3:0] busy_m;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      d1_m = 4'hF;
      d2_m = 4'hF;
      db_m = 4'hF;
      pr_m = 4'h0;
      rl_m = 4'h0;
      for (int i = 0; i < 4; i++) run_m[i] = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        pr_m[i] = 1'b0;
        rl_m[i] = 1'b0;
        if (d2_m[i] != db_m[i]) begin
          run_m[i] = run_m[i] + 1;
          if (run_m[i] == D) begin
            db_m[i] = d2_m[i];
            pr_m[i] = !d2_m[i];
            rl_m[i] = d2_m[i];
            run_m[i] = 0;
          end
        end else run_m[i] = 0;
      end
      d2_m = d1_m;
      d1_m = in_raw;
    end
  end
  always_comb for (int i = 0; i < 4; i++) busy_m[i] = run_m[i] > 0;

  always @(negedge clk) begin
    check("model_db_out", db_out, db_m);
    check("model_press", press_pulse, pr_m);
    check("model_release", release_pulse, rl_m);
    check("model_busy", busy, busy_m);
    check("pulse_exclusive", press_pulse & release_pulse, 4'h0);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int presses;
    step(3);
    reset = 1'b0;
    step(20);
    check("t1_db", db_out, 4'hF);
    check("t1_busy", busy, 4'h0);
    check("t1_press", press_pulse, 4'h0);
    in_raw[0] = 1'b0;
    step(2);
    check("t2_busy_k1", busy, 4'h0);
    step(1);
    check("t2_busy_k2", busy, 4'h1);
    step(6);
    check("t2_busy_k8", busy, 4'h1);
    check("t2_db_k8", db_out, 4'hF);
    check("t2_press_k8", press_pulse, 4'h0);
    step(1);
    check("t2_press_k9", press_pulse, 4'h1);
    check("t2_db_k9", db_out, 4'hE);
    check("t2_busy_k9", busy, 4'h0);
    step(1);
    check("t2_press_k10", press_pulse, 4'h0);
    in_raw[0] = 1'b1;
    step(9);
    check("t2_rel_early", release_pulse, 4'h0);
    step(1);
    check("t2_rel", release_pulse, 4'h1);
    check("t2_rel_db", db_out, 4'hF);
    step(5);
    presses = 0;
    for (int s = 0; s < 10; s++) begin
      in_raw[2] = (s % 2 == 1);
      repeat (3) begin
        step(1);
        if (press_pulse[2]) presses++;
      end
    end
    check("t3_bounce_quiet", 4'(presses), 4'h0);
    check("t3_bounce_db", db_out, 4'hF);
    in_raw[2] = 1'b0;
    step(9);
    check("t3_press_early", press_pulse, 4'h0);
    step(1);
    check("t3_press", press_pulse, 4'h4);
    step(5);
    in_raw[1] = 1'b0;
    step(7);
    in_raw[1] = 1'b1;
    step(12);
    check("t4_glitch7_db", db_out, 4'hB);
    in_raw[1] = 1'b0;
    step(8);
    in_raw[1] = 1'b1;
    step(1);
    check("t4_press_early", press_pulse, 4'h0);
    step(1);
    check("t4_press8", press_pulse, 4'h2);
    check("t4_db8", db_out, 4'h9);
    step(20);
    in_raw[1] = 1'b0;
    step(15);
    check("t5_pre_db", db_out, 4'h9);
    in_raw = 4'b0010;
    step(9);
    check("t5_press_early", press_pulse, 4'h0);
    check("t5_rel_early", release_pulse, 4'h0);
    step(1);
    check("t5_press", press_pulse, 4'h9);
    check("t5_rel", release_pulse, 4'h2);
    check("t5_db", db_out, 4'h2);
    in_raw = 4'hF;
    step(15);
    check("t6_pre_db", db_out, 4'hF);
    in_raw[0] = 1'b0;
    step(7);
    check("t6_busy_cnt5", busy, 4'h1);
    reset = 1'b1;
    #1;
    check("t6_async_db", db_out, 4'hF);
    check("t6_async_busy", busy, 4'h0);
    check("t6_async_press", press_pulse, 4'h0);
    check("t6_async_rel", release_pulse, 4'h0);
    step(1);
    reset = 1'b0;
    step(9);
    check("t6_press_early", press_pulse, 4'h0);
    step(1);
    check("t6_press", press_pulse, 4'h1);
    check("t6_db", db_out, 4'hE);
    step(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
